// File: rtl/ram_fifo_bridge.sv
// ram_fifo_bridge: RAM-side stage behind the interface RAM controller.
// Drains header/data beats from the command FIFO, reads or writes one line of an
// internal word-organised RAM, and returns read beats or a write-ack word through
// the response FIFO.
// Optional feature macro: RAM_BRIDGE_CHECK_EN enables the sticky proto_err flag.
// Without it proto_err is tied low and recovery from bad beats is unchanged.
module ram_fifo_bridge #(
    parameter int unsigned           ADDR_SIZE  = 13,
    parameter int unsigned           WORD_WIDTH = 16,
    parameter int unsigned           BEATS      = 4,
    parameter logic [WORD_WIDTH-1:0] ACK_WORD   = WORD_WIDTH'('hACC)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cmd_empty,
    input  logic [ADDR_SIZE+WORD_WIDTH+1:0] cmd_q,
    output logic                            cmd_rd,
    input  logic                            rsp_full,
    output logic                            rsp_wr,
    output logic [WORD_WIDTH-1:0]           rsp_data,
    output logic                            busy,
    output logic                            proto_err
);

    localparam int unsigned BEAT_BITS = $clog2(BEATS);
    localparam int unsigned IDX_BITS  = ADDR_SIZE + BEAT_BITS;
    localparam int unsigned MEM_WORDS = 2 ** IDX_BITS;
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StWack,
        StRead
    } state_e;

    state_e                 state_q;
    logic [BEAT_BITS-1:0]   beat_q;
    logic [ADDR_SIZE-1:0]   addr_q;

    // Head-of-FIFO fields: {avalid, rnw, addr, wdata}
    logic                   hdr_avalid;
    logic                   hdr_rnw;
    logic [ADDR_SIZE-1:0]   hdr_addr;
    logic [WORD_WIDTH-1:0]  hdr_wdata;

    assign hdr_avalid = cmd_q[ADDR_SIZE+WORD_WIDTH+1];
    assign hdr_rnw    = cmd_q[ADDR_SIZE+WORD_WIDTH];
    assign hdr_addr   = cmd_q[ADDR_SIZE+WORD_WIDTH-1:WORD_WIDTH];
    assign hdr_wdata  = cmd_q[WORD_WIDTH-1:0];

    // Word-organised line store: index is {line address, beat}
    logic [WORD_WIDTH-1:0]  mem [MEM_WORDS];
    logic                   mem_we;
    logic [IDX_BITS-1:0]    mem_waddr;
    logic [IDX_BITS-1:0]    mem_raddr;
    logic [WORD_WIDTH-1:0]  mem_rdata;

    assign mem_raddr = {addr_q, beat_q};
    assign mem_rdata = mem[mem_raddr];

    assign busy = (state_q != StIdle);

    // FIFO handshakes, RAM write port and response data; all quiet while in reset
    always_comb begin
        cmd_rd    = 1'b0;
        rsp_wr    = 1'b0;
        rsp_data  = '0;
        mem_we    = 1'b0;
        mem_waddr = {addr_q, beat_q};
        if (!reset) begin
            case (state_q)
                StIdle: begin
                    cmd_rd = !cmd_empty;
                    // Write header carries word 0 of the line
                    if (!cmd_empty && hdr_avalid && !hdr_rnw) begin
                        mem_we    = 1'b1;
                        mem_waddr = {hdr_addr, {BEAT_BITS{1'b0}}};
                    end
                end
                StWrite: begin
                    // A header mid-burst is left in the FIFO for StIdle to re-see
                    cmd_rd = !cmd_empty && !hdr_avalid;
                    mem_we = !cmd_empty && !hdr_avalid;
                end
                StWack: begin
                    rsp_wr = !rsp_full;
                    if (!rsp_full) begin
                        rsp_data = ACK_WORD;
                    end
                end
                StRead: begin
                    rsp_wr = !rsp_full;
                    if (!rsp_full) begin
                        rsp_data = mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sequencer: line address, beat counter and burst state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            beat_q  <= '0;
            addr_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    // Orphan data beats are popped and dropped without a state change
                    if (!cmd_empty && hdr_avalid) begin
                        addr_q <= hdr_addr;
                        if (hdr_rnw) begin
                            beat_q  <= '0;
                            state_q <= StRead;
                        end else begin
                            beat_q  <= BEAT_BITS'(1);
                            state_q <= StWrite;
                        end
                    end
                end
                StWrite: begin
                    if (!cmd_empty) begin
                        if (hdr_avalid) begin
                            // Abandon the burst: no ack, partial line stays in RAM
                            beat_q  <= '0;
                            state_q <= StIdle;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                            if (beat_q == LAST_BEAT) begin
                                state_q <= StWack;
                            end
                        end
                    end
                end
                StWack: begin
                    if (rsp_wr) begin
                        state_q <= StIdle;
                    end
                end
                StRead: begin
                    if (rsp_wr) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == LAST_BEAT) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= hdr_wdata;
        end
    end

`ifdef RAM_BRIDGE_CHECK_EN
    logic proto_evt;
    logic proto_err_q;

    assign proto_evt = !reset && !cmd_empty &&
                       (((state_q == StIdle) && !hdr_avalid) ||
                        ((state_q == StWrite) && hdr_avalid));

    // Sticky flag for orphan beats and headers that cut a write burst short
    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err_q <= 1'b0;
        end else if (proto_evt) begin
            proto_err_q <= 1'b1;
        end
    end

    assign proto_err = proto_err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule
